// File: rtl/average_channel_scheduler.sv
// -----------------------------------------------------------------------------
// average_channel_scheduler
//
// One 2^LOG2_DEPTH-deep moving-average engine shared by NCH sample channels.
// Each channel has its own history segment in a common RAM, plus its own write
// pointer and running sum. A round-robin arbiter accepts one sample at a time.
// Each accepted sample goes through READ (fetch the oldest sample), UPDATE
// (subtract the old sample, add the new one, store the new one) and OUT (one
// result pulse). That gives one tagged average per accepted sample.
//
// Optional feature (build macro AVG_ROUND_EN):
//   defined   - the average rounds half up: (sum + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH
//   undefined - the average truncates:      sum >> LOG2_DEPTH
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-channel sample valid
//   i_sample_in  packed samples, channel i at [i*DW +: DW]
//   o_req_ready  per-channel accept (one-hot or zero), combinational in IDLE
//   o_avg_valid  one-cycle pulse marking a new average
//   o_avg_ch     channel of the current average
//   o_avg_out    window average (holds its value between pulses)
//   o_busy       history clear in progress
// -----------------------------------------------------------------------------
module average_channel_scheduler #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int LOG2_DEPTH = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NCH-1:0]          i_req_valid,
  input  logic [NCH*DW-1:0]       i_sample_in,
  output logic [NCH-1:0]          o_req_ready,
  output logic                    o_avg_valid,
  output logic [$clog2(NCH)-1:0]  o_avg_ch,
  output logic [DW-1:0]           o_avg_out,
  output logic                    o_busy
);

  localparam int CW    = $clog2(NCH);
  localparam int AW    = CW + LOG2_DEPTH;
  localparam int SW    = DW + LOG2_DEPTH;
  localparam int WORDS = NCH * (1 << LOG2_DEPTH);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_UPDATE,
    S_OUT
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_clr_addr;
  logic [CW-1:0]         r_last_gnt;
  logic [CW-1:0]         r_ch;
  logic [DW-1:0]         r_smp;
  logic                  r_avg_valid;
  logic [CW-1:0]         r_avg_ch;
  logic [DW-1:0]         r_avg_out;
  logic                  r_busy;

  logic [LOG2_DEPTH-1:0] r_wptr [NCH];
  logic [SW-1:0]         r_sum  [NCH];

  // History RAM: no reset, one write port, one registered read port.
  logic [DW-1:0]         r_mem [WORDS];
  logic [DW-1:0]         r_rd_data;

  logic                  w_gnt_found;
  logic [CW-1:0]         w_gnt_idx;
  logic [CW-1:0]         w_cand;
  logic                  w_xfer;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [AW-1:0]         w_raddr;
  logic [DW-1:0]         w_wdata;
  logic [SW-1:0]         w_new_sum;
  logic [DW-1:0]         w_avg;

  // Round-robin search starts one past the last grant. Because NCH is a power
  // of two, the CW-bit addition wraps naturally. The final step (k == NCH)
  // truncates to the last grant itself, so that channel is tried last.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = r_last_gnt + CW'(k);
      if (!w_gnt_found && i_req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_xfer = (r_state == S_IDLE) && w_gnt_found;

  always_comb begin
    o_req_ready = '0;
    if (w_xfer) begin
      o_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // The read and the update of one sample use the same address. The pointer
  // advances only when the UPDATE-cycle write is committed.
  assign w_raddr = {r_ch, r_wptr[r_ch]};

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_raddr;
    w_wdata = r_smp;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end else if (r_state == S_UPDATE) begin
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    if (r_state == S_READ) begin
      r_rd_data <= r_mem[w_raddr];
    end
  end

  // The sum never goes below zero or past its width. It always equals the sum
  // of the stored window, and the oldest sample is part of that sum.
  assign w_new_sum = r_sum[r_ch]
                   - {{LOG2_DEPTH{1'b0}}, r_rd_data}
                   + {{LOG2_DEPTH{1'b0}}, r_smp};

`ifdef AVG_ROUND_EN
  localparam logic [SW:0] RND_HALF = (SW+1)'(1) << (LOG2_DEPTH-1);
  logic [SW:0] w_rnd_sum;
  assign w_rnd_sum = {1'b0, w_new_sum} + RND_HALF;
  // The maximum sum plus half an LSB still shifts down to 2^DW-1, so the
  // result needs no saturation.
  assign w_avg     = DW'(w_rnd_sum >> LOG2_DEPTH);
`else
  assign w_avg     = DW'(w_new_sum >> LOG2_DEPTH);
`endif

  // Per-channel pointer and running sum. Only the channel being updated moves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_wptr[c] <= '0;
        r_sum[c]  <= '0;
      end
    end else if (r_state == S_UPDATE) begin
      for (int c = 0; c < NCH; c++) begin
        if (r_ch == CW'(c)) begin
          r_wptr[c] <= r_wptr[c] + LOG2_DEPTH'(1);
          r_sum[c]  <= w_new_sum;
        end
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_last_gnt  <= CW'(NCH - 1);
      r_ch        <= '0;
      r_smp       <= '0;
      r_avg_valid <= 1'b0;
      r_avg_ch    <= '0;
      r_avg_out   <= '0;
      r_busy      <= 1'b1;
    end else begin
      r_avg_valid <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + AW'(1);
          if (&r_clr_addr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_xfer) begin
            r_ch       <= w_gnt_idx;
            r_smp      <= i_sample_in[w_gnt_idx*DW +: DW];
            r_last_gnt <= w_gnt_idx;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_avg_out   <= w_avg;
          r_avg_ch    <= r_ch;
          r_avg_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign o_avg_valid = r_avg_valid;
  assign o_avg_ch    = r_avg_ch;
  assign o_avg_out   = r_avg_out;
  assign o_busy      = r_busy;

endmodule
